// File: rtl/core_pkg.sv
// Shared core types for the memory stage: access sizes, stage FSM states,
// the hardwired-zero register index and a size normaliser.
package core_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [5:0] ZERO_REG = 6'd0;

  // Encoding 3 has no meaning of its own and behaves as a word access.
  function automatic mem_size_t norm_size(input logic [1:0] s);
    case (s)
      2'd0:    return MEM_BYTE;
      2'd1:    return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// load_align: picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it. Purely combinational. Only used when the
// MEM_SUBWORD_EN build option is defined.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  mem_size_t   size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select then extension; halves are aligned so only off_i[1] matters.
  always_comb begin
    byte_lane = rdata_i[{off_i, 3'b000} +: 8];
    half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      MEM_BYTE: data_o = {{24{byte_lane[7] & ~uns_i}}, byte_lane};
      MEM_HALF: data_o = {{16{half_lane[15] & ~uns_i}}, half_lane};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: takes one op per handshake from execute, performs the data
// memory access for loads/stores over a req/ack bus and emits one registered
// write-back record. Build option MEM_SUBWORD_EN enables byte/half accesses;
// without it every access is a full word.
module memory_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  // upstream
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write_enabled,
  input  logic [5:0]  in_reg_write_dest,
  input  logic [31:0] in_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_size,
  input  logic        in_mem_unsigned,
  input  logic [31:0] in_store_data,
  // data memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // write-back
  output logic        out_valid,
  output logic        reg_write_enabled,
  output logic [5:0]  reg_write_dest,
  output logic [31:0] reg_write_data,
  output logic        misaligned
);

  mem_state_t  state_q, state_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        out_valid_q, out_valid_d, rwe_q, rwe_d, mis_q, mis_d;
  logic [5:0]  rdest_q, rdest_d;
  logic [31:0] rdata_q, rdata_d;
  // Record fields for the op currently waiting on the bus.
  logic [5:0]  pend_dest_q, pend_dest_d;
  logic        pend_wen_q, pend_wen_d;

  logic        is_mem, is_store, wen_ok, acc_mis;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata, load_data;

  assign is_mem   = in_mem_read | in_mem_write;
  assign is_store = in_mem_write;  // read+write together behaves as a store
  assign wen_ok   = in_reg_write_enabled & (in_reg_write_dest != ZERO_REG);

`ifdef MEM_SUBWORD_EN
  mem_size_t  acc_size, pend_size_q, pend_size_d;
  logic       pend_uns_q, pend_uns_d;
  logic [1:0] pend_off_q, pend_off_d;

  assign acc_size = norm_size(in_mem_size);

  // Alignment check and lane-positioned store data / byte enables.
  always_comb begin
    case (acc_size)
      MEM_BYTE: begin
        acc_mis   = 1'b0;
        acc_wstrb = 4'b0001 << in_data[1:0];
        acc_wdata = {4{in_store_data[7:0]}};
      end
      MEM_HALF: begin
        acc_mis   = in_data[0];
        acc_wstrb = 4'b0011 << in_data[1:0];
        acc_wdata = {2{in_store_data[15:0]}};
      end
      default: begin
        acc_mis   = |in_data[1:0];
        acc_wstrb = 4'hF;
        acc_wdata = in_store_data;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i (mem_rdata),
    .off_i   (pend_off_q),
    .size_i  (pend_size_q),
    .uns_i   (pend_uns_q),
    .data_o  (load_data)
  );
`else
  logic unused_subword;
  assign unused_subword = ^{in_mem_size, in_mem_unsigned};
  assign acc_mis   = |in_data[1:0];
  assign acc_wstrb = 4'hF;
  assign acc_wdata = in_store_data;
  assign load_data = mem_rdata;
`endif

  // Next-state: accept in IDLE, hold the request in MEM_WAIT until ack.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    out_valid_d = 1'b0;
    rwe_d       = 1'b0;
    mis_d       = 1'b0;
    rdest_d     = rdest_q;
    rdata_d     = rdata_q;
    pend_dest_d = pend_dest_q;
    pend_wen_d  = pend_wen_q;
`ifdef MEM_SUBWORD_EN
    pend_size_d = pend_size_q;
    pend_uns_d  = pend_uns_q;
    pend_off_d  = pend_off_q;
`endif
    case (state_q)
      MEM_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
            rwe_d       = wen_ok;
            rdest_d     = in_reg_write_dest;
            rdata_d     = in_data;
          end else if (acc_mis) begin
            out_valid_d = 1'b1;
            mis_d       = 1'b1;
            rdest_d     = in_reg_write_dest;
            rdata_d     = in_data;
          end else begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {in_data[31:2], 2'b00};
            mem_wdata_d = acc_wdata;
            mem_wstrb_d = acc_wstrb;
            pend_dest_d = in_reg_write_dest;
            pend_wen_d  = wen_ok & ~is_store;
`ifdef MEM_SUBWORD_EN
            pend_size_d = acc_size;
            pend_uns_d  = in_mem_unsigned;
            pend_off_d  = in_data[1:0];
`endif
          end
        end
      end
      default: begin
        if (mem_ack) begin
          state_d     = MEM_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          out_valid_d = 1'b1;
          rwe_d       = pend_wen_q;
          rdest_d     = pend_dest_q;
          rdata_d     = load_data;
        end
      end
    endcase
  end

  // State and output registers; reset also abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'h0;
      out_valid_q <= 1'b0;
      rwe_q       <= 1'b0;
      mis_q       <= 1'b0;
      rdest_q     <= 6'd0;
      rdata_q     <= 32'd0;
      pend_dest_q <= 6'd0;
      pend_wen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      out_valid_q <= out_valid_d;
      rwe_q       <= rwe_d;
      mis_q       <= mis_d;
      rdest_q     <= rdest_d;
      rdata_q     <= rdata_d;
      pend_dest_q <= pend_dest_d;
      pend_wen_q  <= pend_wen_d;
    end
  end

`ifdef MEM_SUBWORD_EN
  // Load-extraction controls for the pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_size_q <= MEM_WORD;
      pend_uns_q  <= 1'b0;
      pend_off_q  <= 2'd0;
    end else begin
      pend_size_q <= pend_size_d;
      pend_uns_q  <= pend_uns_d;
      pend_off_q  <= pend_off_d;
    end
  end
`endif

  assign in_ready          = (state_q == MEM_IDLE);
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_wstrb         = mem_wstrb_q;
  assign out_valid         = out_valid_q;
  assign reg_write_enabled = rwe_q;
  assign reg_write_dest    = rdest_q;
  assign reg_write_data    = rdata_q;
  assign misaligned        = mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver issues ops and predicts
// results from the access rules, a bus responder acks with random latency,
// and a monitor compares every write-back record against the queue.
module tb_memory_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        in_reg_write_enabled = 1'b0;
  logic [5:0]  in_reg_write_dest = '0;
  logic [31:0] in_data = '0, in_store_data = '0;
  logic        in_mem_read = 1'b0, in_mem_write = 1'b0, in_mem_unsigned = 1'b0;
  logic [1:0]  in_mem_size = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic        out_valid, reg_write_enabled, misaligned;
  logic [5:0]  reg_write_dest;
  logic [31:0] reg_write_data;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write_enabled(in_reg_write_enabled), .in_reg_write_dest(in_reg_write_dest),
    .in_data(in_data), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned), .in_store_data(in_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .reg_write_enabled(reg_write_enabled),
    .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, uns, wen;
    logic [1:0] size;
    logic [5:0] dest;
    logic [31:0] data, sd;
  } op_t;
  typedef struct { logic rwe; logic [5:0] dest; logic [31:0] data; logic mis; } rec_t;

  rec_t expq[$];
  op_t  reqq[$];
  int   total = 0, bad = 0;
  int   force_lat = 0;
  logic force_rd_en = 1'b0;
  logic [31:0] force_rd = '0;
  logic manual = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    total++; bad++;
    $display("FAIL %s @%0t", nm, $time);
  endtask

  // ---- reference model: access width in bytes and derived quantities ----
  function automatic int nbytes(input op_t o);
`ifdef MEM_SUBWORD_EN
    if (o.size == 2'd0) return 1;
    if (o.size == 2'd1) return 2;
`endif
    return 4;
  endfunction

  function automatic bit is_mis(input op_t o);
    return (o.data % nbytes(o)) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input op_t o);
    int n = nbytes(o);
    int m = (1 << n) - 1;
    return 4'((m << (o.data % 4)) & 15);
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    logic [31:0] w;
    int n = nbytes(o);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = o.sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input op_t o, input logic [31:0] rd);
    int n = nbytes(o);
    logic [31:0] v, mask;
    v = rd >> (8 * (o.data % 4));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!o.uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic rec_t rec_direct(input op_t o);
    rec_t r;
    r.dest = o.dest; r.data = o.data;
    if (o.rd || o.wr) begin r.rwe = 1'b0; r.mis = 1'b1; end
    else begin r.rwe = o.wen && (o.dest != 6'd0); r.mis = 1'b0; end
    return r;
  endfunction

  function automatic rec_t rec_mem(input op_t o, input logic [31:0] rd);
    rec_t r;
    r.dest = o.dest; r.mis = 1'b0;
    r.rwe  = !o.wr && o.wen && (o.dest != 6'd0);
    r.data = exp_load(o, rd);
    return r;
  endfunction

  // ---- driver ----
  task automatic issue(input op_t o);
    int w = 0;
    while (!in_ready && w < 500) begin @(negedge clk); w++; end
    if (!in_ready) flag("issue_timeout");
    in_valid = 1'b1;
    in_reg_write_enabled = o.wen; in_reg_write_dest = o.dest; in_data = o.data;
    in_mem_read = o.rd; in_mem_write = o.wr; in_mem_size = o.size;
    in_mem_unsigned = o.uns; in_store_data = o.sd;
    if ((!o.rd && !o.wr) || is_mis(o)) expq.push_back(rec_direct(o));
    else reqq.push_back(o);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic op_t mk(input logic rd, wr, input logic [1:0] sz, input logic uns,
                             input logic [5:0] dest, input logic [31:0] data, sd);
    op_t o;
    o.rd = rd; o.wr = wr; o.size = sz; o.uns = uns; o.wen = 1'b1;
    o.dest = dest; o.data = data; o.sd = sd;
    return o;
  endfunction

  logic resp_active = 1'b0;
  task automatic drain();
    int w = 0;
    while ((expq.size() != 0 || reqq.size() != 0 || resp_active || !in_ready) && w < 500) begin
      @(negedge clk); w++;
    end
    if (w >= 500) flag("drain_timeout");
    @(negedge clk);
  endtask

  // ---- bus responder: checks each request, acks after a chosen latency ----
  op_t cur;
  int  cnt = 0, lat = 1;
  always @(negedge clk) begin
    logic [31:0] rd;
    if (rst) begin
      resp_active = 1'b0;
      if (!manual) mem_ack = 1'b0;
      reqq.delete();
    end else if (!manual) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        resp_active = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
      end else if (mem_req) begin
        if (!resp_active) begin
          if (reqq.size() == 0) begin
            flag("spurious_req");
            mem_ack = 1'b1;
          end else begin
            cur = reqq.pop_front();
            resp_active = 1'b1;
            cnt = 0;
            lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
          end
        end
        if (resp_active) begin
          chk("req_we", {31'd0, mem_we}, {31'd0, cur.wr});
          chk("req_addr", mem_addr, {cur.data[31:2], 2'b00});
          if (cur.wr) begin
            chk("req_wdata", mem_wdata, exp_wdata(cur));
            chk("req_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb(cur)});
          end
          chk("busy_ready", {31'd0, in_ready}, 32'd0);
          cnt++;
          if (cnt >= lat) begin
            rd = force_rd_en ? force_rd : $urandom;
            mem_rdata = rd;
            mem_ack = 1'b1;
            expq.push_back(rec_mem(cur, rd));
          end
        end
      end
    end
  end

  // ---- monitor ----
  always @(negedge clk) begin
    rec_t e;
    if (!rst && out_valid) begin
      if (expq.size() == 0) flag("spurious_out_valid");
      else begin
        e = expq.pop_front();
        chk("wb_mis", {31'd0, misaligned}, {31'd0, e.mis});
        chk("wb_we", {31'd0, reg_write_enabled}, {31'd0, e.rwe});
        if (e.rwe) begin
          chk("wb_dest", {26'd0, reg_write_dest}, {26'd0, e.dest});
          chk("wb_data", reg_write_data, e.data);
        end
      end
    end
  end

  initial begin
    op_t o;
    int w;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_strb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wbdata", reg_write_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU passthrough back-to-back
    issue(mk(0, 0, 2, 0, 6'd5, 32'h1234, 0));
    chk("alu_b2b_ready", {31'd0, in_ready}, 32'd1);
    issue(mk(0, 0, 2, 0, 6'd6, 32'h5678, 0));
    drain();

    // word load with 3-cycle ack
    force_lat = 3; force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
    issue(mk(1, 0, 2, 0, 6'd7, 32'h100, 0));
    drain();

`ifdef MEM_SUBWORD_EN
    force_lat = 1; force_rd = 32'h80FFFFFF;
    issue(mk(1, 0, 0, 0, 6'd8, 32'h103, 0));  // lb
    issue(mk(1, 0, 0, 1, 6'd9, 32'h103, 0));  // lbu
    issue(mk(0, 1, 1, 0, 6'd0, 32'h102, 32'h0000ABCD));  // sh
    drain();
`endif
    force_lat = 0; force_rd_en = 1'b0;

    // misaligned word load, store, x0 destination
    issue(mk(1, 0, 2, 0, 6'd10, 32'h102, 0));
    issue(mk(0, 1, 2, 0, 6'd11, 32'h200, 32'h55));
    issue(mk(0, 0, 2, 0, 6'd0, 32'hCAFE, 0));
    drain();

    // randomized mix
    for (int i = 0; i < 120; i++) begin
      int k = int'($urandom_range(0, 3));
      o = mk(k == 1 || k == 3, k == 2 || k == 3, 2'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom), $urandom, $urandom);
      o.wen = 1'($urandom);
      issue(o);
    end
    drain();

    // reset in the middle of a transaction; a late ack must be ignored
    force_lat = 50;
    issue(mk(1, 0, 2, 0, 6'd12, 32'h300, 0));
    w = 0;
    while (!mem_req && w < 20) begin @(negedge clk); w++; end
    chk("rst_mid_req_seen", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    manual = 1'b1;
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_ov", {31'd0, out_valid}, 32'd0);
      chk("late_ack_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    manual = 1'b0;
    force_lat = 0;
    expq.delete();

    // stage still works after reset recovery
    issue(mk(1, 0, 2, 0, 6'd13, 32'h400, 0));
    issue(mk(0, 0, 2, 0, 6'd14, 32'h77, 0));
    drain();

    chk("final_expq_empty", expq.size(), 32'd0);
    chk("final_reqq_empty", reqq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute watchdog
  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
